mips_dmem_responder: RTL and testbench

Data-memory responder on the far end of the MIPS core's load/store port. It accepts one request at a time over a valid/ready handshake and inserts a programmable number of wait states. It performs byte, halfword or word reads and writes on an internal word-organised RAM, with little-endian lanes and sign or zero extension. It returns a single-cycle response with an error flag for misaligned, illegal-size or out-of-range accesses.

---
 rtl/mips_dmem_responder.sv | 156 +++++++++++++++
 tb/tb_mips_dmem_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS load/store port: one request at a time, programmable wait
// states, little-endian byte/half/word access to a word-organised RAM with an error response.
module mips_dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntInit = (WAIT_CYCLES == 0) ? '0 : CntW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, sgn_q;
  logic [1:0]      size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic            err_q;
  logic            accept, exec;

  logic [31:0] mem [DEPTH_WORDS];

  // Fields of the access being executed: with zero wait states it runs on the accept edge.
  logic                  e_we, e_sgn;
  logic [1:0]            e_size;
  logic [ADDR_WIDTH-1:0] e_addr;
  logic [31:0]           e_wdata;
  logic [IdxW-1:0]       idx;
  logic [31:0]           cur_word, wr_word, load_data;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic                  acc_err;

  assign accept = req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      sgn_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        sgn_q   <= req_signed;
        size_q  <= req_size;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (exec) begin
        rdata_q <= (acc_err || e_we) ? 32'h0 : load_data;
        err_q   <= acc_err;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && exec && e_we && !acc_err) begin
      mem[idx] <= wr_word;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    exec    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          cnt_d = CntInit;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            exec    = 1'b1;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          exec    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
  end

  always_comb begin
    e_we    = (state_q == StIdle) ? req_we     : we_q;
    e_sgn   = (state_q == StIdle) ? req_signed : sgn_q;
    e_size  = (state_q == StIdle) ? req_size   : size_q;
    e_addr  = (state_q == StIdle) ? req_addr   : addr_q;
    e_wdata = (state_q == StIdle) ? req_wdata  : wdata_q;

    idx      = e_addr[IdxW+1:2];
    cur_word = mem[idx];
    lane_b   = cur_word[{e_addr[1:0], 3'b000} +: 8];
    lane_h   = cur_word[{e_addr[1], 4'b0000} +: 16];

    acc_err = (e_size == 2'b11) ||
              (e_size == 2'b01 && e_addr[0]) ||
              (e_size == 2'b10 && e_addr[1:0] != 2'b00) ||
              (|(e_addr >> (IdxW + 2)));

    wr_word   = cur_word;
    load_data = cur_word;
    unique case (e_size)
      2'b00: begin
        wr_word[{e_addr[1:0], 3'b000} +: 8] = e_wdata[7:0];
        load_data = {{24{e_sgn & lane_b[7]}}, lane_b};
      end
      2'b01: begin
        wr_word[{e_addr[1], 4'b0000} +: 16] = e_wdata[15:0];
        load_data = {{16{e_sgn & lane_h[15]}}, lane_h};
      end
      2'b10:   wr_word = e_wdata;
      default: wr_word = cur_word;
    endcase
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Bench for mips_dmem_responder: directed steps plus randomized accesses against a byte-level
// memory model, on a 2-wait-state instance and a zero-wait-state instance.
module tb_mips_dmem_responder;

  localparam int unsigned Depth    = 256;
  localparam int unsigned W        = 2;
  localparam int unsigned MemBytes = Depth * 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 2-wait-state instance
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  // zero-wait-state instance
  logic        z_valid, z_ready, z_we, z_signed;
  logic [1:0]  z_size;
  logic [31:0] z_addr, z_wdata;
  logic        z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  mips_dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(W), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mips_dmem_responder #(.DEPTH_WORDS(Depth), .WAIT_CYCLES(0), .ADDR_WIDTH(32)) dut0 (
    .clk(clk), .rst(rst), .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we),
    .req_size(z_size), .req_signed(z_signed), .req_addr(z_addr), .req_wdata(z_wdata),
    .rsp_valid(z_rsp_valid), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0] mref [MemBytes];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-addressed reference: returns expected rdata/err and applies stores.
  task automatic model(input bit we, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output bit er);
    int n;
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    er = (sz == 2'd3) || (a % n != 0) || (a >= MemBytes);
    rd = 32'h0;
    if (er) return;
    if (we) begin
      for (int i = 0; i < n; i++) mref[a + i] = wd[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = mref[a + i];
      if (n < 4 && sg && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 1);
      rd = v;
    end
  endtask

  // Runs one access on the 2-wait instance; called and returns at a falling edge.
  task automatic xact(input string tag, input bit we, input logic [1:0] sz, input bit sg,
                      input logic [31:0] a, input logic [31:0] wd, input bit chk_data,
                      output logic [31:0] rd, output logic er);
    int n;
    logic [7:0] vh, rh;
    logic [31:0] m_rd;
    bit m_er;
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check({tag, ".ready_timeout"}, 32'd0, 32'd1);
      req_valid = 1'b0;
      rd = 'x; er = 1'bx;
      return;
    end
    @(posedge clk);
    vh = '0; rh = '0;
    rd = 'x; er = 1'bx;
    for (int i = 0; i <= W + 1; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      vh[i] = rsp_valid;
      rh[i] = req_ready;
      if (i == W) begin
        rd = rsp_rdata;
        er = rsp_err;
      end
    end
    check({tag, ".valid_timing"}, {24'h0, vh}, 32'h1 << W);
    check({tag, ".ready_timing"}, {24'h0, rh}, 32'h1 << (W + 1));
    model(we, sz, sg, a, wd, m_rd, m_er);
    check({tag, ".err"}, {31'h0, er}, {31'h0, m_er});
    if (chk_data) check({tag, ".rdata"}, rd, m_rd);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [5:0]  zv, zr;
  bit          any_rsp;

  initial begin
    rst = 1'b1;
    req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    z_valid = 0; z_we = 0; z_size = 0; z_signed = 0; z_addr = 0; z_wdata = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset.ready", {31'h0, req_ready}, 32'd1);
    check("reset.valid", {31'h0, rsp_valid}, 32'd0);
    check("reset.rdata", rsp_rdata, 32'd0);
    check("reset.err", {31'h0, rsp_err}, 32'd0);

    xact("st_word", 1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 1, rd, er);
    xact("ld_word", 0, 2'd2, 0, 32'h10, 32'h0, 1, rd, er);
    check("ld_word.const", rd, 32'hDEADBEEF);
    xact("st_byte", 1, 2'd0, 0, 32'h11, 32'h80, 1, rd, er);
    xact("ld_sbyte", 0, 2'd0, 1, 32'h11, 32'h0, 1, rd, er);
    check("ld_sbyte.const", rd, 32'hFFFFFF80);
    xact("ld_ubyte", 0, 2'd0, 0, 32'h11, 32'h0, 1, rd, er);
    check("ld_ubyte.const", rd, 32'h00000080);
    xact("ld_merged", 0, 2'd2, 0, 32'h10, 32'h0, 1, rd, er);
    check("ld_merged.const", rd, 32'hDEAD80EF);
    xact("ld_half_mis", 0, 2'd1, 0, 32'h13, 32'h0, 1, rd, er);
    check("ld_half_mis.const", {rd[31:1], er}, 32'h1);
    xact("st_word_mis", 1, 2'd2, 0, 32'h12, 32'h55555555, 1, rd, er);
    xact("ld_unchanged", 0, 2'd2, 0, 32'h10, 32'h0, 1, rd, er);
    check("ld_unchanged.const", rd, 32'hDEAD80EF);
    xact("ld_size3", 0, 2'd3, 0, 32'h10, 32'h0, 1, rd, er);
    xact("ld_oor", 0, 2'd2, 0, 32'h400, 32'h0, 1, rd, er);
    check("ld_oor.const", {31'h0, er}, 32'd1);
    xact("ld_top", 0, 2'd2, 0, 32'h3FC, 32'h0, 0, rd, er);
    check("ld_top.const", {31'h0, er}, 32'd0);

    // Store aborted by reset in its first wait cycle must leave memory untouched.
    xact("st_aaaa", 1, 2'd2, 0, 32'h20, 32'h0000AAAA, 1, rd, er);
    req_we = 1; req_size = 2'd2; req_signed = 0; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    any_rsp = 0;
    check("abort.ready", {31'h0, req_ready}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      any_rsp |= rsp_valid;
      @(negedge clk);
    end
    check("abort.no_rsp", {31'h0, any_rsp}, 32'd0);
    xact("ld_after_abort", 0, 2'd2, 0, 32'h20, 32'h0, 1, rd, er);
    check("ld_after_abort.const", rd, 32'h0000AAAA);

    // Randomized phase: seed a 32-word region, then mixed accesses.
    for (int i = 0; i < 32; i++) xact("seed", 1, 2'd2, 0, 32'(i * 4), $urandom, 1, rd, er);
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 255));
      else a = 32'($urandom_range(0, 127));
      xact("rand", 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), a, $urandom, 1, rd, er);
    end

    // Zero-wait instance: store, then three back-to-back loads with req_valid held high.
    z_we = 1; z_size = 2'd2; z_addr = 32'h0; z_wdata = 32'hCAFEF00D; z_valid = 1'b1;
    @(negedge clk);
    z_valid = 1'b0;
    repeat (2) @(negedge clk);
    z_we = 0; z_signed = 0; z_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      zv[i] = z_rsp_valid;
      zr[i] = z_ready;
      if (z_rsp_valid) check("zw.rdata", z_rsp_rdata, 32'hCAFEF00D);
      if (i == 5) z_valid = 1'b0;
      @(negedge clk);
    end
    check("zw.ready_pattern", {26'h0, zr}, 32'b010101);
    check("zw.valid_pattern", {26'h0, zv}, 32'b101010);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
